// File: rtl/saber_power_if.sv
// Signal bundle between the on/off register, the power controller and the blade stages.
// Plain level signalling, no handshake: inputs are sampled every clock, and outputs are registered state.
interface saber_power_if #(
   parameter int WIDTH  = 8,
   parameter int RAMP_W = 4
);
   logic              on_req;
   logic [1:0]        usage;
   logic              power_mode;
   logic [WIDTH-1:0]  level;
   logic              warn;
   logic              empty;
   logic              blade_en;
   logic [RAMP_W-1:0] blade_ramp;
   logic [2:0]        state;

   modport master (
      output on_req, usage, power_mode,
      input  level, warn, empty, blade_en, blade_ramp, state
   );

   modport slave (
      input  on_req, usage, power_mode,
      output level, warn, empty, blade_en, blade_ramp, state
   );
endinterface

// File: rtl/saber_power_ctrl.sv
// Saber power controller: battery level with charge and usage-dependent drain,
// a low-battery warning with hysteresis, the ignite/retract ramp and a lockout on an empty battery.
module saber_power_ctrl #(
   parameter int WIDTH       = 8,
   parameter int MAX_LEVEL   = 255,
   parameter int RESET_LEVEL = 0,
   parameter int CHARGE_RATE = 2,
   parameter int RATE0       = 0,
   parameter int RATE1       = 1,
   parameter int RATE2       = 2,
   parameter int RATE3       = 4,
   parameter int TICK_DIV    = 4,
   parameter int WARN_LO     = 32,
   parameter int WARN_HI     = 48,
   parameter int IGNITE_CYC  = 8,
   parameter int RAMP_W      = 4,
   parameter int RESTART_MIN = 16
) (
   input logic          clk,
   input logic          rst,
   saber_power_if.slave pwr
);
   localparam logic [2:0] ST_OFF      = 3'd0;
   localparam logic [2:0] ST_IGNITE   = 3'd1;
   localparam logic [2:0] ST_ON       = 3'd2;
   localparam logic [2:0] ST_RETRACT  = 3'd3;
   localparam logic [2:0] ST_DEPLETED = 3'd4;

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int LW    = WIDTH + 1;

   localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TICK_DIV - 1);
   localparam logic [LW-1:0]     MAX_L      = LW'(MAX_LEVEL);
   localparam logic [LW-1:0]     CHG_L      = LW'(CHARGE_RATE);
   localparam logic [WIDTH-1:0]  WARN_LO_L  = WIDTH'(WARN_LO);
   localparam logic [WIDTH-1:0]  WARN_HI_L  = WIDTH'(WARN_HI);
   localparam logic [WIDTH-1:0]  RESTART_L  = WIDTH'(RESTART_MIN);
   localparam logic [WIDTH-1:0]  RESET_L    = WIDTH'(RESET_LEVEL);
   localparam logic [RAMP_W-1:0] RAMP_FULL  = RAMP_W'(IGNITE_CYC);
   localparam logic [RAMP_W-1:0] RAMP_LAST  = RAMP_W'(IGNITE_CYC - 1);
   localparam logic [RAMP_W-1:0] RAMP_ONE   = RAMP_W'(1);
   localparam logic              RESET_WARN = (RESET_LEVEL < WARN_LO);

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0]  level_q, level_d;
   logic              warn_q, warn_d;
   logic [2:0]        state_q, state_d;
   logic [RAMP_W-1:0] ramp_q, ramp_d;

   logic              tick;
   logic              drain_active;
   logic              can_light;
   logic [LW-1:0]     rate;
   logic [LW-1:0]     sum;
   logic [LW-1:0]     diff;
   logic [RAMP_W-1:0] ramp_up;
   logic [RAMP_W-1:0] ramp_dn;

   assign tick         = (cnt_q == CNT_LAST);
   assign cnt_d        = tick ? '0 : cnt_q + CNT_W'(1);
   assign drain_active = tick && pwr.power_mode && (state_q == ST_ON);
   assign can_light    = (level_q >= RESTART_L);
   assign ramp_up      = ramp_q + RAMP_ONE;
   assign ramp_dn      = ramp_q - RAMP_ONE;

   always_comb begin
      rate = LW'(RATE0);
      case (pwr.usage)
         2'd0:    rate = LW'(RATE0);
         2'd1:    rate = LW'(RATE1);
         2'd2:    rate = LW'(RATE2);
         default: rate = LW'(RATE3);
      endcase
   end

   // One extra bit carries the overflow/borrow so both directions clamp cleanly.
   assign sum  = {1'b0, level_q} + CHG_L;
   assign diff = {1'b0, level_q} - rate;

   always_comb begin
      level_d = level_q;
      if (tick) begin
         if (!pwr.power_mode) begin
            level_d = (sum > MAX_L) ? MAX_L[WIDTH-1:0] : sum[WIDTH-1:0];
         end else if (state_q == ST_ON) begin
            level_d = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
         end
      end
   end

   always_comb begin
      warn_d = warn_q;
      if (level_d < WARN_LO_L) begin
         warn_d = 1'b1;
      end else if (level_d >= WARN_HI_L) begin
         warn_d = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      ramp_d  = ramp_q;
      case (state_q)
         ST_OFF: begin
            ramp_d = '0;
            if (pwr.on_req && can_light) begin
               ramp_d  = RAMP_ONE;
               state_d = (RAMP_ONE == RAMP_FULL) ? ST_ON : ST_IGNITE;
            end
         end
         ST_IGNITE: begin
            if (!pwr.on_req) begin
               ramp_d  = ramp_dn;
               state_d = (ramp_dn == '0) ? ST_OFF : ST_RETRACT;
            end else begin
               ramp_d  = ramp_up;
               state_d = (ramp_up == RAMP_FULL) ? ST_ON : ST_IGNITE;
            end
         end
         ST_ON: begin
            ramp_d = RAMP_FULL;
            // Running dry beats a release in the same cycle so the lockout cannot be skipped.
            if (drain_active && (level_d == '0)) begin
               ramp_d  = '0;
               state_d = ST_DEPLETED;
            end else if (!pwr.on_req) begin
               ramp_d  = RAMP_LAST;
               state_d = (RAMP_LAST == '0) ? ST_OFF : ST_RETRACT;
            end
         end
         ST_RETRACT: begin
            if (pwr.on_req && can_light) begin
               ramp_d  = ramp_up;
               state_d = (ramp_up == RAMP_FULL) ? ST_ON : ST_IGNITE;
            end else begin
               ramp_d  = ramp_dn;
               state_d = (ramp_dn == '0) ? ST_OFF : ST_RETRACT;
            end
         end
         ST_DEPLETED: begin
            ramp_d = '0;
            if (!pwr.on_req && can_light) begin
               state_d = ST_OFF;
            end
         end
         default: begin
            ramp_d  = '0;
            state_d = ST_OFF;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         level_q <= RESET_L;
         warn_q  <= RESET_WARN;
         state_q <= ST_OFF;
         ramp_q  <= '0;
      end else begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
         warn_q  <= warn_d;
         state_q <= state_d;
         ramp_q  <= ramp_d;
      end
   end

   assign pwr.level      = level_q;
   assign pwr.warn       = warn_q;
   assign pwr.empty      = (level_q == '0);
   assign pwr.blade_en   = (state_q == ST_IGNITE) || (state_q == ST_ON) || (state_q == ST_RETRACT);
   assign pwr.blade_ramp = ramp_q;
   assign pwr.state      = state_q;
endmodule

// File: tb/tb_saber_power_ctrl.sv
// Directed bench for saber_power_ctrl at default parameters; clock E<n> is the n-th edge after reset release.
module tb_saber_power_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   saber_power_if #(.WIDTH(8), .RAMP_W(4)) pwr ();

   saber_power_ctrl dut (
      .clk (clk),
      .rst (rst),
      .pwr (pwr)
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      pwr.on_req     = 1'b0;
      pwr.power_mode = 1'b0;
      pwr.usage      = 2'd0;
      step(2);
      rst = 1'b0;
   endtask

   // Charge from 0 to 48 (warn cleared), then ignite with drain at usage 3; ON at E104.
   task automatic bring_up_48();
      do_reset();
      step(96);
      check("up48_level", int'(pwr.level), 48);
      check("up48_warn", int'(pwr.warn), 0);
      pwr.on_req     = 1'b1;
      pwr.power_mode = 1'b1;
      pwr.usage      = 2'd3;
      step(8);
      check("up48_state_on", int'(pwr.state), 2);
      check("up48_ramp", int'(pwr.blade_ramp), 8);
      check("up48_level_held", int'(pwr.level), 48);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

   initial begin
      // Reset values and charging with saturation
      do_reset();
      check("rst_level", int'(pwr.level), 0);
      check("rst_warn", int'(pwr.warn), 1);
      check("rst_empty", int'(pwr.empty), 1);
      check("rst_state", int'(pwr.state), 0);
      check("rst_blade_en", int'(pwr.blade_en), 0);
      check("rst_ramp", int'(pwr.blade_ramp), 0);
      step(3);
      check("chg_e3", int'(pwr.level), 0);
      step(1);
      check("chg_e4", int'(pwr.level), 2);
      step(59);
      check("chg_e63", int'(pwr.level), 30);
      step(1);
      check("chg_e64", int'(pwr.level), 32);
      check("chg_e64_warn", int'(pwr.warn), 1);
      step(31);
      check("chg_e95", int'(pwr.level), 46);
      check("chg_e95_warn", int'(pwr.warn), 1);
      step(1);
      check("chg_e96", int'(pwr.level), 48);
      check("chg_e96_warn", int'(pwr.warn), 0);
      step(412);
      check("chg_e508", int'(pwr.level), 254);
      step(4);
      check("chg_e512_sat", int'(pwr.level), 255);
      step(8);
      check("chg_e520_hold", int'(pwr.level), 255);
      check("chg_empty", int'(pwr.empty), 0);

      // Ignition gated by RESTART_MIN
      do_reset();
      pwr.on_req = 1'b1;
      step(20);
      check("gate_level10", int'(pwr.level), 10);
      check("gate_state_off", int'(pwr.state), 0);
      check("gate_blade_off", int'(pwr.blade_en), 0);
      step(12);
      check("gate_level16", int'(pwr.level), 16);
      check("gate_still_off", int'(pwr.state), 0);
      step(1);
      check("ign_state", int'(pwr.state), 1);
      check("ign_ramp1", int'(pwr.blade_ramp), 1);
      check("ign_blade_en", int'(pwr.blade_en), 1);
      step(6);
      check("ign_ramp7", int'(pwr.blade_ramp), 7);
      check("ign_state7", int'(pwr.state), 1);
      step(1);
      check("ign_on", int'(pwr.state), 2);
      check("ign_ramp8", int'(pwr.blade_ramp), 8);

      // Drain at usage 3, warn hysteresis, depletion lockout
      bring_up_48();
      step(4);
      check("drn_e108", int'(pwr.level), 44);
      step(12);
      check("drn_e120", int'(pwr.level), 32);
      check("drn_e120_warn", int'(pwr.warn), 0);
      step(4);
      check("drn_e124", int'(pwr.level), 28);
      check("drn_e124_warn", int'(pwr.warn), 1);
      step(24);
      check("drn_e148", int'(pwr.level), 4);
      check("drn_e148_state", int'(pwr.state), 2);
      step(4);
      check("dep_level", int'(pwr.level), 0);
      check("dep_state", int'(pwr.state), 4);
      check("dep_ramp", int'(pwr.blade_ramp), 0);
      check("dep_blade_en", int'(pwr.blade_en), 0);
      check("dep_empty", int'(pwr.empty), 1);
      pwr.power_mode = 1'b0;
      step(40);
      check("dep_rechg_level", int'(pwr.level), 20);
      check("dep_rechg_state", int'(pwr.state), 4);
      check("dep_rechg_blade", int'(pwr.blade_en), 0);
      pwr.on_req = 1'b0;
      step(1);
      check("dep_exit_off", int'(pwr.state), 0);

      // Abort ignition to full retract, then re-ignite mid-retract
      do_reset();
      step(32);
      check("ab_level16", int'(pwr.level), 16);
      pwr.on_req = 1'b1;
      step(5);
      check("ab_ign_ramp5", int'(pwr.blade_ramp), 5);
      pwr.on_req = 1'b0;
      step(1);
      check("ab_ret_state", int'(pwr.state), 3);
      check("ab_ret_ramp4", int'(pwr.blade_ramp), 4);
      step(3);
      check("ab_ret_ramp1", int'(pwr.blade_ramp), 1);
      check("ab_ret_state1", int'(pwr.state), 3);
      step(1);
      check("ab_off_state", int'(pwr.state), 0);
      check("ab_off_ramp", int'(pwr.blade_ramp), 0);
      check("ab_off_blade", int'(pwr.blade_en), 0);
      pwr.on_req = 1'b1;
      step(5);
      check("re_ign_ramp5", int'(pwr.blade_ramp), 5);
      pwr.on_req = 1'b0;
      step(3);
      check("re_ret_ramp2", int'(pwr.blade_ramp), 2);
      pwr.on_req = 1'b1;
      step(1);
      check("re_ign_state", int'(pwr.state), 1);
      check("re_ign_ramp3", int'(pwr.blade_ramp), 3);
      step(4);
      check("re_ign_ramp7", int'(pwr.blade_ramp), 7);
      step(1);
      check("re_on_state", int'(pwr.state), 2);
      check("re_on_ramp8", int'(pwr.blade_ramp), 8);

      // Depletion wins over release on the same tick
      bring_up_48();
      step(44);
      check("pri_level4", int'(pwr.level), 4);
      step(3);
      pwr.on_req = 1'b0;
      step(1);
      check("pri_state_dep", int'(pwr.state), 4);
      check("pri_level0", int'(pwr.level), 0);
      check("pri_empty", int'(pwr.empty), 1);
      check("pri_ramp0", int'(pwr.blade_ramp), 0);

      // Reset while ON at level 100
      do_reset();
      pwr.on_req = 1'b1;
      step(200);
      check("mr_level100", int'(pwr.level), 100);
      check("mr_state_on", int'(pwr.state), 2);
      check("mr_warn0", int'(pwr.warn), 0);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      check("mr_state", int'(pwr.state), 0);
      check("mr_level", int'(pwr.level), 0);
      check("mr_ramp", int'(pwr.blade_ramp), 0);
      check("mr_blade_en", int'(pwr.blade_en), 0);
      check("mr_warn", int'(pwr.warn), 1);
      step(3);
      check("mr_tick_e3", int'(pwr.level), 0);
      step(1);
      check("mr_tick_e4", int'(pwr.level), 2);
      check("mr_stays_off", int'(pwr.state), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
